div8_seq: RTL and testbench



---
 rtl/div_pkg.sv | 12 +
 rtl/div8_seq_if.sv | 25 ++
 rtl/div_step.sv | 22 ++
 rtl/div8_seq.sv | 92 +++++++++
 tb/tb_div8_seq.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  localparam int DIV_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div8_seq_if.sv
// Operand and result handshakes of the divider.
// master = producer/consumer side, slave = the divider itself.
interface div8_seq_if #(
  parameter int WIDTH = div_pkg::DIV_WIDTH_DEFAULT
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, emit the quotient bit.
module div_step #(
  parameter int WIDTH = div_pkg::DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH:0]   r,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   r_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;

  // Trial subtraction; the compare uses the full shifted value so no bit is lost.
  always_comb begin
    shifted = {r[WIDTH-1:0], q_msb};
    q_bit   = ({r, q_msb} >= {2'b00, divisor});
    r_next  = q_bit ? (shifted - {1'b0, divisor}) : shifted;
  end

endmodule

// File: rtl/div8_seq.sv
// Iterative unsigned restoring divider, one quotient bit per clock,
// with valid/ready handshakes on operands and results.
module div8_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic          clk,
  input  logic          reset_n,
  div8_seq_if.slave     bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_e       state_q, state_d;
  logic [CW-1:0]    count_q;
  logic [WIDTH:0]   r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] dvs_q;
  logic             dbz_q;

  logic             accept;
  logic [WIDTH:0]   r_next;
  logic             q_bit;

  assign accept = (state_q == IDLE) && bus.in_valid;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r       (r_q),
    .q_msb   (q_q[WIDTH-1]),
    .divisor (dvs_q),
    .r_next  (r_next),
    .q_bit   (q_bit)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic. A divide-by-zero still passes through CALC for one
  // idle cycle so its result appears one edge after the accept.
  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid)    state_d = CALC;
      CALC:    if (count_q == '0)   state_d = DONE;
      DONE:    if (bus.out_ready)   state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  // Datapath: load on accept, one restoring step per CALC cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      dbz_q   <= 1'b0;
    end else if (accept) begin
      dvs_q <= bus.divisor;
      if (bus.divisor == '0) begin
        dbz_q   <= 1'b1;
        count_q <= '0;
        q_q     <= '1;
        r_q     <= {1'b0, bus.dividend};
      end else begin
        dbz_q   <= 1'b0;
        count_q <= CW'(WIDTH - 1);
        q_q     <= bus.dividend;
        r_q     <= '0;
      end
    end else if ((state_q == CALC) && !dbz_q) begin
      r_q <= r_next;
      q_q <= {q_q[WIDTH-2:0], q_bit};
      if (count_q != '0) count_q <= count_q - CW'(1);
    end
  end

  // Handshake flags follow the state; results come straight from registers.
  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.quotient    = q_q;
  assign bus.remainder   = r_q[WIDTH-1:0];
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_div8_seq.sv
// Self-checking bench for div8_seq: directed vector table, backpressure,
// reset-abort sequence, and randomized operands against an arithmetic model.
module tb_div8_seq;
  import div_pkg::*;

  localparam int W = DIV_WIDTH_DEFAULT;
  localparam int TIMEOUT = 40;

  typedef struct {
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    int           stall;
    bit           poke;
    logic [W-1:0] exp_q;
    logic [W-1:0] exp_r;
    logic         exp_z;
    int           exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  div8_seq_if #(.WIDTH(W)) bus ();

  div8_seq #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Runs one operation; returns the captured result and latency in edges
  // after the accepting edge. Handshake checks happen inside.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int stall, input bit poke,
                        output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic z, output int lat);
    bit ir_bad = 1'b0;
    bit st_bad = 1'b0;
    @(negedge clk);
    check("in_ready before accept", bus.in_ready, 1);
    bus.in_valid  = 1'b1;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < TIMEOUT) begin
      if (bus.in_ready) ir_bad = 1'b1;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    q = bus.quotient;
    r = bus.remainder;
    z = bus.div_by_zero;
    for (int i = 0; i < stall; i++) begin
      if (poke && i == 1) begin
        bus.in_valid = 1'b1;
        bus.dividend = 8'd50;
        bus.divisor  = 8'd2;
      end
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (!bus.out_valid || bus.in_ready || bus.quotient !== q ||
          bus.remainder !== r || bus.div_by_zero !== z) st_bad = 1'b1;
    end
    check("in_ready low while busy", ir_bad, 0);
    if (stall > 0) check("result held under backpressure", st_bad, 0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("out_valid drops after consume", bus.out_valid, 0);
    check("in_ready back after consume", bus.in_ready, 1);
  endtask

  vec_t vecs[$];

  initial begin
    logic [W-1:0] q, r, a, b;
    logic         z;
    int           lat, sample;
    bit           early;

    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;

    // Reset values while reset is held.
    #12;
    check("reset in_ready",    bus.in_ready, 1);
    check("reset out_valid",   bus.out_valid, 0);
    check("reset quotient",    bus.quotient, 0);
    check("reset remainder",   bus.remainder, 0);
    check("reset div_by_zero", bus.div_by_zero, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed vectors, expected values worked out by hand.
    vecs.push_back('{8'd200, 8'd7,   0, 1'b0, 8'd28,  8'd4, 1'b0, 8});
    vecs.push_back('{8'd255, 8'd1,   0, 1'b0, 8'd255, 8'd0, 1'b0, 8});
    vecs.push_back('{8'd3,   8'd10,  0, 1'b0, 8'd0,   8'd3, 1'b0, 8});
    vecs.push_back('{8'd0,   8'd5,   0, 1'b0, 8'd0,   8'd0, 1'b0, 8});
    vecs.push_back('{8'd255, 8'd255, 0, 1'b0, 8'd1,   8'd0, 1'b0, 8});
    vecs.push_back('{8'd5,   8'd0,   0, 1'b0, 8'd255, 8'd5, 1'b1, 1});
    vecs.push_back('{8'd9,   8'd3,   0, 1'b0, 8'd3,   8'd0, 1'b0, 8});
    vecs.push_back('{8'd100, 8'd9,   5, 1'b1, 8'd11,  8'd1, 1'b0, 8});
    vecs.push_back('{8'd1,   8'd2,   0, 1'b0, 8'd0,   8'd1, 1'b0, 8});

    foreach (vecs[i]) begin
      run_op(vecs[i].dividend, vecs[i].divisor, vecs[i].stall, vecs[i].poke, q, r, z, lat);
      check($sformatf("vec%0d quotient", i),    q,   vecs[i].exp_q);
      check($sformatf("vec%0d remainder", i),   r,   vecs[i].exp_r);
      check($sformatf("vec%0d div_by_zero", i), z,   vecs[i].exp_z);
      check($sformatf("vec%0d latency", i),     lat, vecs[i].exp_lat);
    end

    // Reset in the middle of a calculation discards the operation.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.dividend = 8'd200;
    bus.divisor  = 8'd7;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort in_ready",    bus.in_ready, 1);
    check("abort out_valid",   bus.out_valid, 0);
    check("abort quotient",    bus.quotient, 0);
    check("abort remainder",   bus.remainder, 0);
    check("abort div_by_zero", bus.div_by_zero, 0);
    @(negedge clk);
    reset_n = 1'b1;
    early = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid) early = 1'b1;
    end
    check("no out_valid after abort", early, 0);
    run_op(8'd17, 8'd4, 0, 1'b0, q, r, z, lat);
    check("post-abort quotient",    q,   4);
    check("post-abort remainder",   r,   1);
    check("post-abort div_by_zero", z,   0);
    check("post-abort latency",     lat, 8);

    // Randomized operands with random consumer stalls.
    for (int n = 0; n < 500; n++) begin
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(1, 255));
      sample = $urandom_range(0, 3);
      run_op(a, b, sample, 1'b0, q, r, z, lat);
      check("rand quotient",    q, a / b);
      check("rand remainder",   r, a % b);
      check("rand identity",    32'(q) * 32'(b) + 32'(r), 32'(a));
      check("rand rem < div",   (r < b), 1);
      check("rand div_by_zero", z, 0);
      check("rand latency",     lat, 8);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
